cover_toggle_collector: RTL and testbench
=========================================

Name: cover_toggle_collector

Overview:
Synthesizable successor to the per-bit DPI toggle-cover reporter. It records first-hit events on a parametrised vector of toggle-cover points in a sticky bitmap. Newly covered points are serialized as absolute cover indices over a valid/ready stream, and running coverage statistics are maintained alongside. It sits between the instrumented design's cover-point wires and the coverage drain and uplink logic, and it also works in non-DPI builds.

Parameters:
WIDTH, 27, number of cover points monitored (1..1024).
COVER_INDEX, 0, global index of bit 0; out_index = COVER_INDEX + bit position.
COVER_TOTAL, 10906, total cover points in the design; used only for the range check (COVER_INDEX + WIDTH <= COVER_TOTAL, elaboration error otherwise).
IDX_W, 32, width of out_index.
CNT_W, clog2(WIDTH+1), width of covered_count.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high reset.
valid  in  WIDTH  per-point hit strobes, sampled every cycle.
enable  in  1  when 0, valid is ignored (no bitmap update).
clear  in  1  synchronous coverage restart.
out_valid  out  1  out_index holds a newly covered point.
out_ready  in  1  consumer accepts out_index.
out_index  out  IDX_W  absolute cover index of the newly covered point.
covered_count  out  CNT_W  number of distinct points hit since reset/clear.
all_covered  out  1  covered_count == WIDTH.

Behaviour:
- Reset (async assert, release synchronous to clock): covered bitmap = 0, pending bitmap = 0, out_valid = 0, out_index = 0, covered_count = 0, all_covered = 0.
- new_hits = (enable ? valid : 0) & ~covered. At each edge: covered |= new_hits; pending |= new_hits; covered_count += popcount(new_hits).
- A point is reported exactly once per reset/clear epoch. Repeat hits are ignored. Simultaneous hits on any number of bits are all recorded, so the block never drops a hit.
- Output register load condition: (!out_valid || out_ready) && pending != 0. On load:
  - out_index = COVER_INDEX + lowest set bit of pending (zero-extended to IDX_W, modulo 2^IDX_W).
  - out_valid = 1.
  - That pending bit is cleared on the same edge.
- If out_valid && out_ready and pending == 0: out_valid = 0 next cycle. out_index holds its last value.
- Latency: hit sampled at edge E, pending set at E, out_valid high after edge E+1 (2 cycles from strobe to visible output when the output is free).
- Throughput: 1 index per cycle with out_ready held at 1.
- Stream protocol:
  - out_index is stable while out_valid && !out_ready.
  - out_valid never drops without acceptance, except on clear or reset.
- Ordering: indices emitted in ascending bit order among points pending at each load. Later hits on a lower bit may overtake earlier pending higher bits; this is accepted.
- A new hit on bit k in the same cycle that another bit is loaded: both handled. A bit cannot be loaded and newly hit in the same cycle, because covered is already set.
- clear (priority over everything except reset): next cycle covered = 0, pending = 0, covered_count = 0, out_valid = 0. valid in the clear cycle is discarded. An in-flight output is dropped even if out_ready = 1 in that cycle.
- all_covered is registered and asserts in the cycle covered_count reaches WIDTH.
- Reset asserted mid-stream: all state returns to reset values immediately. No partial index is emitted.

Decomposition:
- Shared package cover_pkg:
  - clog2 function.
  - Default IDX_W constant.
  - Typedef for the cover index type.
- One sub-module: cover_prio_enc (WIDTH-bit lowest-set-bit encoder producing index plus any-set flag), purely combinational. A tree implementation is allowed for large WIDTH.
- Popcount of new_hits stays inline.

Test Plan:
- COVER_INDEX=100; pulse valid[3] one cycle with out_ready=1 -> out_valid high 2 cycles later, out_index=103, covered_count=1; next cycle out_valid=0.
- Single cycle valid bits {0,5,26}, out_ready=1 -> out_index 100, 105, 126 on 3 consecutive cycles; covered_count=3.
- Same as above with out_ready=0 for 5 cycles -> out_index stays 100, out_valid stays 1; then ready=1 -> 105, 126 follow with no loss.
- Re-pulse valid[3] after it was reported, and pulse valid[7] with enable=0 -> no output, count unchanged.
- Drive valid = all ones for one cycle -> 27 indices 100..126 in order, all_covered=1 after the count reaches 27; then clear while out_valid=1 -> out_valid=0, count=0, all_covered=0 next cycle; a fresh valid[3] re-reports 103.
- Assert reset asynchronously mid-stream (between edges) with out_valid=1 and pending bits set -> outputs drop to 0 immediately; after release, no stale indices are emitted.

Source files
------------

// File: rtl/cover_pkg.sv
// Shared types and helpers for the toggle-cover collector slice.
package cover_pkg;

  localparam int COVER_IDX_W = 32;

  typedef logic [COVER_IDX_W-1:0] cover_idx_t;

  // Ceiling log2, never below 1 so that a 1-point monitor still gets a real bus.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cover_toggle_collector_if.sv
// Valid/ready stream carrying absolute cover indices to the coverage drain.
interface cover_stream_if
  import cover_pkg::*;
#(
  parameter int IDX_W = COVER_IDX_W
) ();

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;

  modport master (output out_valid, output out_index, input out_ready);
  modport slave  (input out_valid, input out_index, output out_ready);

endinterface

// File: rtl/cover_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest asserted bit plus an any-set flag.
module cover_prio_enc
  import cover_pkg::*;
#(
  parameter int WIDTH = 27,
  parameter int EW    = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [EW-1:0]    idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = EW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cover_toggle_collector.sv
// Sticky first-hit toggle-cover recorder; newly covered points are streamed
// out as absolute cover indices, lowest pending bit first.
module cover_toggle_collector
  import cover_pkg::*;
#(
  parameter int WIDTH       = 27,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 10906,
  parameter int IDX_W       = COVER_IDX_W,
  parameter int CNT_W       = clog2(WIDTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  valid,
  input  logic              enable,
  input  logic              clear,
  cover_stream_if.master    stream,
  output logic [CNT_W-1:0]  covered_count,
  output logic              all_covered
);

  localparam int EW = clog2(WIDTH);

  if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
    $error("cover_toggle_collector: WIDTH must be 1..1024");
  end
  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_range
    $error("cover_toggle_collector: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
  end
  if ($bits(stream.out_index) != IDX_W) begin : g_bad_idx_w
    $error("cover_toggle_collector: stream IDX_W does not match IDX_W");
  end

  logic [WIDTH-1:0] covered;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] new_hits;
  logic [WIDTH-1:0] pend_low;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] next_count;
  logic [EW-1:0]    pend_idx;
  logic             pend_any;
  logic             load;

  assign new_hits = (enable ? valid : '0) & ~covered;

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hit_cnt = hit_cnt + CNT_W'(new_hits[i]);
    end
  end

  assign next_count = covered_count + hit_cnt;

  cover_prio_enc #(
    .WIDTH (WIDTH),
    .EW    (EW)
  ) u_prio_enc (
    .vec (pending),
    .idx (pend_idx),
    .any (pend_any)
  );

  // Two's-complement trick isolates the same bit the encoder selected.
  assign pend_low = pending & (~pending + WIDTH'(1));
  assign load     = (!stream.out_valid || stream.out_ready) && pend_any;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      covered          <= '0;
      pending          <= '0;
      covered_count    <= '0;
      all_covered      <= 1'b0;
      stream.out_valid <= 1'b0;
      stream.out_index <= '0;
    end else if (clear) begin
      covered          <= '0;
      pending          <= '0;
      covered_count    <= '0;
      all_covered      <= 1'b0;
      stream.out_valid <= 1'b0;
    end else begin
      covered       <= covered | new_hits;
      pending       <= (pending | new_hits) & ~(load ? pend_low : '0);
      covered_count <= next_count;
      all_covered   <= (next_count == CNT_W'(WIDTH));
      if (load) begin
        stream.out_valid <= 1'b1;
        stream.out_index <= IDX_W'(COVER_INDEX) + IDX_W'(pend_idx);
      end else if (stream.out_ready) begin
        stream.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Directed bench for cover_toggle_collector with COVER_INDEX = 100.
module tb_cover_toggle_collector;
  import cover_pkg::*;

  localparam int WIDTH = 27;
  localparam int CIDX  = 100;
  localparam int CNT_W = clog2(WIDTH + 1);

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] valid;
  logic             enable;
  logic             clear;
  logic [CNT_W-1:0] covered_count;
  logic             all_covered;

  int tests_run;
  int tests_failed;

  cover_stream_if #(.IDX_W(COVER_IDX_W)) stream ();

  cover_toggle_collector #(
    .WIDTH       (WIDTH),
    .COVER_INDEX (CIDX),
    .COVER_TOTAL (10906),
    .IDX_W       (COVER_IDX_W),
    .CNT_W       (CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .valid         (valid),
    .enable        (enable),
    .clear         (clear),
    .stream        (stream.master),
    .covered_count (covered_count),
    .all_covered   (all_covered)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_idx(input string tag, input int exp);
    check({tag, " valid"}, 64'(stream.out_valid), 64'd1);
    check({tag, " index"}, 64'(stream.out_index), 64'(exp));
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    reset            = 1'b1;
    valid            = '0;
    enable           = 1'b1;
    clear            = 1'b0;
    stream.out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // reset state
    check("rst valid", 64'(stream.out_valid), 64'd0);
    check("rst index", 64'(stream.out_index), 64'd0);
    check("rst count", 64'(covered_count), 64'd0);
    check("rst allcov", 64'(all_covered), 64'd0);

    // single hit on bit 3: two-cycle latency, one-cycle pulse
    valid = 27'h8;
    tick();
    valid = '0;
    check("t1 e0 valid", 64'(stream.out_valid), 64'd0);
    check("t1 count", 64'(covered_count), 64'd1);
    tick();
    expect_idx("t1 out", 103);
    tick();
    check("t1 drop", 64'(stream.out_valid), 64'd0);

    // bits 0,5,26 together stream out back-to-back
    valid = (27'd1 << 0) | (27'd1 << 5) | (27'd1 << 26);
    tick();
    valid = '0;
    check("t2 count", 64'(covered_count), 64'd4);
    tick(); expect_idx("t2 a", 100);
    tick(); expect_idx("t2 b", 105);
    tick(); expect_idx("t2 c", 126);
    tick();
    check("t2 drop", 64'(stream.out_valid), 64'd0);

    // repeat hit and disabled hit are ignored
    valid = 27'h8;
    tick();
    valid  = 27'h80;
    enable = 1'b0;
    tick();
    valid  = '0;
    enable = 1'b1;
    check("t4 v0", 64'(stream.out_valid), 64'd0);
    tick();
    check("t4 v1", 64'(stream.out_valid), 64'd0);
    tick();
    check("t4 v2", 64'(stream.out_valid), 64'd0);
    check("t4 count", 64'(covered_count), 64'd4);

    // clear, then the same three bits with backpressure
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr count", 64'(covered_count), 64'd0);
    stream.out_ready = 1'b0;
    valid = (27'd1 << 0) | (27'd1 << 5) | (27'd1 << 26);
    tick();
    valid = '0;
    tick();
    expect_idx("t3 first", 100);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_idx("t3 hold", 100);
    end
    stream.out_ready = 1'b1;
    tick(); expect_idx("t3 b", 105);
    tick(); expect_idx("t3 c", 126);
    tick();
    check("t3 drop", 64'(stream.out_valid), 64'd0);
    check("t3 count", 64'(covered_count), 64'd3);

    // everything at once after a clear
    clear = 1'b1;
    tick();
    clear = 1'b0;
    valid = '1;
    tick();
    valid = '0;
    check("t5 count", 64'(covered_count), 64'd27);
    check("t5 allcov", 64'(all_covered), 64'd1);
    for (int i = 0; i < WIDTH; i++) begin
      tick();
      expect_idx("t5 seq", CIDX + i);
    end
    check("t5 allcov end", 64'(all_covered), 64'd1);
    // out_valid is high holding 126; clear drops it despite ready
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t5 clr valid", 64'(stream.out_valid), 64'd0);
    check("t5 clr count", 64'(covered_count), 64'd0);
    check("t5 clr allcov", 64'(all_covered), 64'd0);
    valid = 27'h8;
    tick();
    valid = '0;
    tick();
    expect_idx("t5 rehit", 103);
    tick();

    // asynchronous reset mid-stream with pending bits
    stream.out_ready = 1'b0;
    valid = 27'h16;
    tick();
    valid = '0;
    tick();
    expect_idx("t6 pre", 101);
    #2;
    reset = 1'b1;
    #1;
    check("t6 rst valid", 64'(stream.out_valid), 64'd0);
    check("t6 rst index", 64'(stream.out_index), 64'd0);
    check("t6 rst count", 64'(covered_count), 64'd0);
    tick();
    reset = 1'b0;
    stream.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6 no stale", 64'(stream.out_valid), 64'd0);
    end
    check("t6 count", 64'(covered_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
